// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus bundle.
// Groups the instruction-memory request/ack channel, the redirect input and the
// instruction valid/ready channel toward the execution unit.
//   master : fetch unit side (drives IMemReq/IMemAddr and the Instr* outputs)
//   slave  : environment side (memory + execution unit)
// Parameters: AW - word-address width.
interface instr_fetch_unit_if #(
  parameter int unsigned AW = 10
);
  logic          IMemReq;
  logic [AW-1:0] IMemAddr;
  logic          IMemAck;
  logic [31:0]   IMemData;
  logic          Redirect;
  logic [AW-1:0] RedirectPC;
  logic          InstrValid;
  logic          InstrReady;
  logic [31:0]   Instr;
  logic [AW-1:0] InstrPC;
  logic [AW-1:0] InstrPCplus1;

  modport master (
    output IMemReq, IMemAddr,
    input  IMemAck, IMemData,
    input  Redirect, RedirectPC,
    output InstrValid, Instr, InstrPC, InstrPCplus1,
    input  InstrReady
  );

  modport slave (
    input  IMemReq, IMemAddr,
    output IMemAck, IMemData,
    output Redirect, RedirectPC,
    input  InstrValid, Instr, InstrPC, InstrPCplus1,
    output InstrReady
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Owns the fetch PC, keeps at most one request outstanding to instruction memory,
// buffers returned words in a DEPTH-entry prefetch FIFO and hands them to the execution
// unit under valid/ready. Redirects flush the FIFO and retarget fetch.
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_unit_if.master (IMem req/ack, Redirect, Instr valid/ready)
//   StallCnt, FlushCnt : saturating performance counters, only with FETCH_PERF_EN defined
// Optional feature macro: FETCH_PERF_EN
module instr_fetch_unit #(
  parameter int unsigned   AW       = 10,
  parameter int unsigned   DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic                Clk,
  input logic                Rst_n,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        StallCnt,
  output logic [15:0]        FlushCnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e        state_q;
  logic          req_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] pc_q;

  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q   [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic          ack_valid, flush, push, pop, room, head_valid;
  logic [CW-1:0] count_next;
  logic [AW-1:0] addr_inc;

  always_comb begin
    // Acks are only meaningful while a request is actually outstanding.
    ack_valid  = bus.IMemAck & req_q;
    flush      = bus.Redirect;
    head_valid = (count_q != '0);
    push       = ack_valid & (state_q == StReq) & ~flush;
    pop        = head_valid & bus.InstrReady & ~flush;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count_q + CW'(push) - CW'(pop);
    end
    room     = (count_next < CW'(DEPTH));
    addr_inc = addr_q + AW'(1);
  end

  // Request FSM; IMemReq/IMemAddr come straight from registers so they hold steady.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        StIdle: begin
          if (flush) begin
            pc_q    <= bus.RedirectPC;
            addr_q  <= bus.RedirectPC;
            req_q   <= 1'b1;
            state_q <= StReq;
          end else if (room) begin
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (flush) begin
            pc_q <= bus.RedirectPC;
            if (ack_valid) begin
              // Acked word is stale; go straight to the redirect target.
              addr_q <= bus.RedirectPC;
            end else begin
              state_q <= StDrop;
            end
          end else if (ack_valid) begin
            pc_q <= addr_inc;
            if (room) begin
              addr_q <= addr_inc;
            end else begin
              req_q   <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        StDrop: begin
          if (flush) begin
            pc_q <= bus.RedirectPC;
          end
          if (ack_valid) begin
            addr_q  <= flush ? bus.RedirectPC : pc_q;
            state_q <= StReq;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_next;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= bus.IMemData;
      pc_mem_q[wr_ptr_q]   <= addr_q;
    end
  end

  assign bus.IMemReq      = req_q;
  assign bus.IMemAddr     = addr_q;
  assign bus.InstrValid   = head_valid;
  assign bus.Instr        = head_valid ? data_mem_q[rd_ptr_q] : '0;
  assign bus.InstrPC      = head_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign bus.InstrPCplus1 = head_valid ? (pc_mem_q[rd_ptr_q] + AW'(1)) : '0;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!head_valid && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (RESET_PC 0 and 0x3FE) with a
// simple latency-programmable memory model; returned word = 0xA5000000 | address.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n0, rst_n1;
  int   n_tests = 0;
  int   n_fail  = 0;

  instr_fetch_unit_if #(.AW(10)) bus0 ();
  instr_fetch_unit_if #(.AW(10)) bus1 ();

`ifdef FETCH_PERF_EN
  logic [15:0] stall0, flush0, stall1, flush1;
`endif

  instr_fetch_unit #(.AW(10), .DEPTH(2), .RESET_PC(10'h000)) u_dut0 (
    .Clk      (clk),
    .Rst_n    (rst_n0),
    .bus      (bus0)
`ifdef FETCH_PERF_EN
    ,
    .StallCnt (stall0),
    .FlushCnt (flush0)
`endif
  );

  instr_fetch_unit #(.AW(10), .DEPTH(2), .RESET_PC(10'h3FE)) u_dut1 (
    .Clk      (clk),
    .Rst_n    (rst_n1),
    .bus      (bus1)
`ifdef FETCH_PERF_EN
    ,
    .StallCnt (stall1),
    .FlushCnt (flush1)
`endif
  );

  always #5 clk = ~clk;

  // Memory model state and observation logs
  int          lat0 = 1;
  int          wait0 = 0;
  int          wait1 = 0;
  bit          mem_en0 = 1'b1;
  int          ack_cnt0 = 0;
  bit          was_req0, was_ack0, was_req1, was_ack1;
  logic [31:0] req_log0[$];
  logic [31:0] pop_pc0[$];
  logic [31:0] pop_p1_0[$];
  logic [31:0] pop_ins0[$];
  logic [31:0] req_log1[$];
  logic [31:0] pop_pc1[$];
  logic [31:0] pop_p1_1[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs0();
    req_log0.delete();
    pop_pc0.delete();
    pop_p1_0.delete();
    pop_ins0.delete();
    ack_cnt0 = 0;
    wait0    = 0;
  endtask

  // One clock: record what the coming edge sees, then advance to the negedge
  // and let the memory models respond.
  task automatic step();
    if (bus0.InstrValid && bus0.InstrReady && !bus0.Redirect) begin
      pop_pc0.push_back(32'(bus0.InstrPC));
      pop_p1_0.push_back(32'(bus0.InstrPCplus1));
      pop_ins0.push_back(bus0.Instr);
    end
    if (bus0.IMemReq && bus0.IMemAck) ack_cnt0++;
    if (bus1.InstrValid && bus1.InstrReady) begin
      pop_pc1.push_back(32'(bus1.InstrPC));
      pop_p1_1.push_back(32'(bus1.InstrPCplus1));
    end
    was_req0 = bus0.IMemReq;
    was_ack0 = bus0.IMemReq && bus0.IMemAck;
    was_req1 = bus1.IMemReq;
    was_ack1 = bus1.IMemReq && bus1.IMemAck;
    @(posedge clk);
    @(negedge clk);
    if (bus0.IMemReq && (!was_req0 || was_ack0)) req_log0.push_back(32'(bus0.IMemAddr));
    if (bus1.IMemReq && (!was_req1 || was_ack1)) req_log1.push_back(32'(bus1.IMemAddr));
    if (mem_en0) begin
      bus0.IMemAck = 1'b0;
      if (rst_n0 && bus0.IMemReq) begin
        if (wait0 >= lat0) begin
          bus0.IMemAck  = 1'b1;
          bus0.IMemData = 32'hA500_0000 | 32'(bus0.IMemAddr);
          wait0 = 0;
        end else begin
          wait0++;
        end
      end else begin
        wait0 = 0;
      end
    end
    bus1.IMemAck = 1'b0;
    if (rst_n1 && bus1.IMemReq) begin
      if (wait1 >= 1) begin
        bus1.IMemAck  = 1'b1;
        bus1.IMemData = 32'hA500_0000 | 32'(bus1.IMemAddr);
        wait1 = 0;
      end else begin
        wait1++;
      end
    end else begin
      wait1 = 0;
    end
  endtask

  task automatic reset_dut0();
    rst_n0 = 1'b0;
    bus0.IMemAck = 1'b0;
    step();
    step();
    rst_n0 = 1'b1;
    clear_logs0();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  guard;
    bit  saw5;
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    bus0.IMemAck = 1'b0; bus0.IMemData = '0; bus0.Redirect = 1'b0;
    bus0.RedirectPC = '0; bus0.InstrReady = 1'b1;
    bus1.IMemAck = 1'b0; bus1.IMemData = '0; bus1.Redirect = 1'b0;
    bus1.RedirectPC = '0; bus1.InstrReady = 1'b1;
    repeat (3) step();

    // Reset state
    check_eq("rst_req", 32'(bus0.IMemReq), 32'd0);
    check_eq("rst_addr", 32'(bus0.IMemAddr), 32'h000);
    check_eq("rst_valid", 32'(bus0.InstrValid), 32'd0);
    check_eq("rst_instr", bus0.Instr, 32'd0);
    check_eq("rst_pc", 32'(bus0.InstrPC), 32'd0);
    check_eq("rst_pc1", 32'(bus0.InstrPCplus1), 32'd0);
    check_eq("rst_addr_1", 32'(bus1.IMemAddr), 32'h3FE);

    // Streaming, 1-cycle memory latency
    rst_n0 = 1'b1;
    clear_logs0();
    step();
    check_eq("first_req", 32'(bus0.IMemReq), 32'd1);
    check_eq("first_addr", 32'(bus0.IMemAddr), 32'h000);
    step();
    step();
    check_eq("c3_valid", 32'(bus0.InstrValid), 32'd1);
    check_eq("c3_instr", bus0.Instr, 32'hA500_0000);
    check_eq("c3_pc", 32'(bus0.InstrPC), 32'h000);
    check_eq("c3_pc1", 32'(bus0.InstrPCplus1), 32'h001);
    guard = 0;
    while (pop_pc0.size() < 3 && guard < 30) begin step(); guard++; end
    check_eq("stream_pops", 32'(pop_pc0.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("stream_pc%0d", i), pop_pc0[i], 32'(i));
      check_eq($sformatf("stream_pc1_%0d", i), pop_p1_0[i], 32'(i + 1));
    end

    // Back-pressure: FIFO fills to DEPTH, fetch stops
    bus0.InstrReady = 1'b0;
    guard = 0;
    while (bus0.IMemReq && guard < 30) begin step(); guard++; end
    repeat (5) step();
    check_eq("bp_req_off", 32'(bus0.IMemReq), 32'd0);
    check_eq("bp_valid", 32'(bus0.InstrValid), 32'd1);
    check_eq("bp_buffered", 32'(ack_cnt0 - pop_pc0.size()), 32'd2);
    check_eq("bp_head_pc", 32'(bus0.InstrPC), 32'(pop_pc0.size()));
    bus0.InstrReady = 1'b1;
    guard = 0;
    while (pop_pc0.size() < 12 && guard < 60) begin step(); guard++; end
    for (int i = 0; i < 12; i++) begin
      check_eq($sformatf("bp_seq_pc%0d", i), pop_pc0[i], 32'(i));
      check_eq($sformatf("bp_seq_ins%0d", i), pop_ins0[i], 32'hA500_0000 | 32'(i));
    end

    // Redirect while request to 0x005 is outstanding (3-cycle latency)
    reset_dut0();
    lat0 = 3;
    guard = 0;
    while (!(bus0.IMemReq && bus0.IMemAddr == 10'h005) && guard < 60) begin step(); guard++; end
    check_eq("rd1_reach5", 32'(bus0.IMemAddr), 32'h005);
    check_eq("rd1_valid_pre", 32'(bus0.InstrValid), 32'd1);
    check_eq("rd1_pc_pre", 32'(bus0.InstrPC), 32'h004);
    bus0.Redirect = 1'b1;
    bus0.RedirectPC = 10'h040;
    step();
    bus0.Redirect = 1'b0;
    check_eq("rd1_flushed", 32'(bus0.InstrValid), 32'd0);
    check_eq("rd1_req_held", 32'(bus0.IMemReq), 32'd1);
    check_eq("rd1_addr_held", 32'(bus0.IMemAddr), 32'h005);
    repeat (20) step();
    check_eq("rd1_req5", req_log0[5], 32'h005);
    check_eq("rd1_req_next", req_log0[6], 32'h040);
    check_eq("rd1_pop4", pop_pc0[4], 32'h040);
    check_eq("rd1_ins4", pop_ins0[4], 32'hA500_0040);
    saw5 = 1'b0;
    foreach (pop_pc0[i]) if (pop_pc0[i] == 32'h005 || pop_pc0[i] == 32'h004) saw5 = 1'b1;
    check_eq("rd1_no_stale", 32'(saw5), 32'd0);

    // Redirect in the same cycle as IMemAck
    reset_dut0();
    lat0 = 1;
    guard = 0;
    while (!(bus0.IMemAck && bus0.IMemAddr == 10'h003) && guard < 40) begin step(); guard++; end
    check_eq("rd2_ack3", 32'(bus0.IMemAck), 32'd1);
    bus0.Redirect = 1'b1;
    bus0.RedirectPC = 10'h100;
    step();
    bus0.Redirect = 1'b0;
    check_eq("rd2_req", 32'(bus0.IMemReq), 32'd1);
    check_eq("rd2_addr", 32'(bus0.IMemAddr), 32'h100);
    check_eq("rd2_valid_r1", 32'(bus0.InstrValid), 32'd0);
    step();
    check_eq("rd2_valid_r2", 32'(bus0.InstrValid), 32'd0);
    step();
    check_eq("rd2_valid_r3", 32'(bus0.InstrValid), 32'd1);
    check_eq("rd2_pc_r3", 32'(bus0.InstrPC), 32'h100);
    check_eq("rd2_ins_r3", bus0.Instr, 32'hA500_0100);
    check_eq("rd2_pc1_r3", 32'(bus0.InstrPCplus1), 32'h101);
    step();
    check_eq("rd2_pop3", pop_pc0[3], 32'h100);

    // Reset mid-request, then a late ack
    reset_dut0();
    mem_en0 = 1'b0;
    bus0.IMemAck = 1'b0;
    step();
    check_eq("mr_req", 32'(bus0.IMemReq), 32'd1);
    rst_n0 = 1'b0;
    #1;
    check_eq("mr_rst_req", 32'(bus0.IMemReq), 32'd0);
    check_eq("mr_rst_addr", 32'(bus0.IMemAddr), 32'h000);
    check_eq("mr_rst_valid", 32'(bus0.InstrValid), 32'd0);
    step();
    check_eq("mr_hold_req", 32'(bus0.IMemReq), 32'd0);
    rst_n0 = 1'b1;
    clear_logs0();
    bus0.IMemAck = 1'b1;
    bus0.IMemData = 32'hDEAD_BEEF;
    step();
    bus0.IMemAck = 1'b0;
    check_eq("mr_restart_req", 32'(bus0.IMemReq), 32'd1);
    check_eq("mr_restart_addr", 32'(bus0.IMemAddr), 32'h000);
    check_eq("mr_valid_a", 32'(bus0.InstrValid), 32'd0);
    step();
    check_eq("mr_valid_b", 32'(bus0.InstrValid), 32'd0);
    mem_en0 = 1'b1;
    guard = 0;
    while (pop_pc0.size() < 1 && guard < 20) begin step(); guard++; end
    check_eq("mr_first_pc", pop_pc0[0], 32'h000);
    check_eq("mr_first_ins", pop_ins0[0], 32'hA500_0000);

    // RESET_PC near the top of the address space: wrap-around
    rst_n1 = 1'b1;
    repeat (10) step();
    check_eq("wrap_req0", req_log1[0], 32'h3FE);
    check_eq("wrap_req1", req_log1[1], 32'h3FF);
    check_eq("wrap_req2", req_log1[2], 32'h000);
    check_eq("wrap_pc0", pop_pc1[0], 32'h3FE);
    check_eq("wrap_pc1", pop_pc1[1], 32'h3FF);
    check_eq("wrap_pc2", pop_pc1[2], 32'h000);
    check_eq("wrap_pc1_0", pop_p1_1[0], 32'h3FF);
    check_eq("wrap_pc1_1", pop_p1_1[1], 32'h000);
    check_eq("wrap_pc1_2", pop_p1_1[2], 32'h001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
